// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: prefetch queue fed by a 1-cycle synchronous imem, head decoded into MIPS fields.
// Optional IFQ_BYPASS_EN: a response arriving at an empty queue is presented combinationally in the same cycle.
module instr_fetch_queue #(
    parameter int ADDR_WIDTH  = 8,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               fetch_en,
    input  logic                               flush,
    input  logic [ADDR_WIDTH-1:0]              flush_pc,
    output logic                               imem_req,
    output logic [ADDR_WIDTH-1:0]              imem_addr,
    input  logic [31:0]                        imem_rdata,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ADDR_WIDTH-1:0]              out_pc,
    output logic [31:0]                        out_instr,
    output logic [5:0]                         opcode,
    output logic [4:0]                         rs,
    output logic [4:0]                         rt,
    output logic [4:0]                         rd,
    output logic [4:0]                         shamt,
    output logic [5:0]                         funct,
    output logic [15:0]                        immediate,
    output logic [31:0]                        imm_sext,
    output logic [25:0]                        jump_target,
    output logic [$clog2(QUEUE_DEPTH):0]       q_count
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] fpc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic [31:0]           q_instr [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc    [QUEUE_DEPTH];

    logic                  q_empty;
    logic                  bypass_hit;
    logic [31:0]           head_instr;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [31:0]           dec_instr;
    logic                  pop;
    logic                  pop_q;
    logic                  push;
    logic [CNT_W:0]        credit;

    assign q_empty = (count == '0);

`ifdef IFQ_BYPASS_EN
    assign bypass_hit = q_empty && inflight;
`else
    assign bypass_hit = 1'b0;
`endif

    assign head_instr = bypass_hit ? imem_rdata  : q_instr[head];
    assign head_pc    = bypass_hit ? inflight_pc : q_pc[head];
    assign out_valid  = !q_empty || bypass_hit;
    assign pop        = out_valid && out_ready;

    // A bypassed word that is accepted never occupies a queue slot.
    assign push  = inflight && !(bypass_hit && out_ready);
    assign pop_q = out_ready && !q_empty;

    // Credits cover queued words plus the one in flight, so the queue cannot overflow.
    assign credit    = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign imem_req  = rst_n && fetch_en && !flush && (credit < (CNT_W+1)'(QUEUE_DEPTH));
    assign imem_addr = fpc;
    assign q_count   = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc      <= '0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (flush) begin
            fpc      <= flush_pc;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) fpc <= fpc + ADDR_WIDTH'(1);
            if (push)     tail <= tail + PTR_W'(1);
            if (pop_q)    head <= head + PTR_W'(1);
            unique case ({push, pop_q})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Data storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (imem_req) inflight_pc <= fpc;
        if (push && !flush) begin
            q_instr[tail] <= imem_rdata;
            q_pc[tail]    <= inflight_pc;
        end
    end

    assign dec_instr   = out_valid ? head_instr : 32'h0;
    assign out_pc      = out_valid ? head_pc : '0;
    assign out_instr   = dec_instr;
    assign opcode      = dec_instr[31:26];
    assign rs          = dec_instr[25:21];
    assign rt          = dec_instr[20:16];
    assign rd          = dec_instr[15:11];
    assign shamt       = dec_instr[10:6];
    assign funct       = dec_instr[5:0];
    assign immediate   = dec_instr[15:0];
    assign imm_sext    = {{16{dec_instr[15]}}, dec_instr[15:0]};
    assign jump_target = dec_instr[25:0];

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Parametrised instruction fetch and decode stage. It fetches 32-bit MIPS-format words from a synchronous instruction memory and buffers them in a prefetch queue. The head entry is presented as decoded fields (opcode, RS, RT, RD, shamt, funct, immediate, sign-extended immediate, jump target) through a valid/ready handshake to the control unit and register file. It supports redirect (flush to a new PC).

## Interface
Parameters:
- ADDR_WIDTH, 8, word-address width of instruction memory; the PC wraps modulo 2^ADDR_WIDTH
- QUEUE_DEPTH, 4, prefetch queue entries; power of two, 2..16

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  permits new memory requests
- flush  in  1  redirect: discard queue and in-flight fetch
- flush_pc  in  ADDR_WIDTH  new fetch word address when flush=1
- imem_req  out  1  memory read request this cycle
- imem_addr  out  ADDR_WIDTH  word address of request
- imem_rdata  in  32  read data, valid exactly 1 cycle after imem_req
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head
- out_pc  out  ADDR_WIDTH  word address of head instruction
- out_instr  out  32  raw head word
- opcode  out  6  instr[31:26]
- rs  out  5  instr[25:21]
- rt  out  5  instr[20:16]
- rd  out  5  instr[15:11]
- shamt  out  5  instr[10:6]
- funct  out  6  instr[5:0]
- immediate  out  16  instr[15:0]
- imm_sext  out  32  instr[15:0] sign-extended from bit 15
- jump_target  out  26  instr[25:0]
- q_count  out  $clog2(QUEUE_DEPTH)+1  current queue occupancy

## Operation
- Fetch PC register `fpc`. Request condition: fetch_en && !flush && (q_count + inflight - pop) < QUEUE_DEPTH.
  - pop = out_valid && out_ready.
  - inflight = request issued in the previous cycle and not killed.
- On a request: imem_addr = fpc, imem_req = 1, and fpc increments by 1 on the edge. The increment wraps from 2^ADDR_WIDTH-1 to 0.
- On the cycle after a live request, imem_rdata is pushed to the queue tail together with its PC.
- Queue is a circular buffer with head/tail pointers and a count. Push and pop in the same cycle leave the count unchanged. Overflow is impossible because of credit accounting.
- Decode fields are combinational slices of the head entry. When out_valid = 0, all field outputs, out_instr, and out_pc are driven to 0.
- Flush has top priority:
  - queue is emptied and the in-flight response is marked dead (its data is ignored next cycle);
  - fpc is loaded with flush_pc;
  - no request is issued during the flush cycle;
  - a pop in the flush cycle is not honoured.
- Reset values:
  - fpc = 0, count = 0, pointers = 0, inflight = 0;
  - imem_req = 0, out_valid = 0, all decode outputs = 0.
- Reset asserted mid-operation drops all queued and in-flight words immediately (asynchronous).

## Timing
- Fetch latency: request at cycle N, word in queue at edge N+1, out_valid = 1 in cycle N+1 after that edge (visible cycle N+2 of issue counting from 1) when the queue was empty.
- Sustained throughput: 1 instruction/cycle when out_ready is held high and QUEUE_DEPTH >= 2.
- Full queue: imem_req = 0 until a pop frees a credit. The request resumes in the same cycle as the pop.
- out_valid/out_ready: the head is held stable while out_valid && !out_ready.
- First request after flush: cycle following flush, at address flush_pc.

## Configuration
- IFQ_BYPASS_EN defined: when the queue is empty and a live response arrives, the response drives out_valid and the decode outputs combinationally in the same cycle.
  - If out_ready = 1, the word is consumed without entering the queue.
  - Otherwise it is pushed as normal.
  - Latency is 1 cycle from request.
- IFQ_BYPASS_EN undefined: all responses pass through the queue, and out_valid and all outputs depend only on registered state. Latency is 2 cycles.

## Test plan
- Reset, then fetch_en = 1, out_ready = 1, memory word[k] = k*0x01010101:
  - imem_addr sequence 0,1,2,…;
  - out_pc follows it 2 cycles later (1 cycle with IFQ_BYPASS_EN);
  - one instruction per cycle.
- Decode check, head word 0x8C22FFFC: opcode = 0x23, rs = 1, rt = 2, rd = 31, shamt = 31, funct = 0x3C, immediate = 0xFFFC, imm_sext = 0xFFFFFFFC, jump_target = 0x022FFFC.
- out_ready = 0 with QUEUE_DEPTH = 4: exactly 4 requests issued, then q_count = 4 and imem_req = 0. One pop restores one request in the same cycle.
- Flush with flush_pc = 0x40 while the queue holds 3 entries and 1 is in flight:
  - next cycle q_count = 0, out_valid = 0;
  - the stale response is dropped;
  - next imem_addr = 0x40.
- ADDR_WIDTH = 4, start via flush_pc = 14: addresses 14, 15, 0, 1.
- Assert rst_n = 0 mid-stream for less than one clock period: out_valid, imem_req, and q_count become 0 without a clock edge.
